// File: rtl/pipe_stage_elastic_pkg.sv
// Shared constants for the CPU pipeline stage registers: per-stage payload
// widths, flush keep-masks, counter width and the occupancy state type.
package pipe_pkg;

  localparam int IF_ID_W  = 96;
  localparam int ID_EX_W  = 300;
  localparam int EX_MEM_W = 200;
  localparam int MEM_WB_W = 150;

  localparam int CNT_W_DEFAULT = 16;

  // Bits [63:32] of every stage payload carry the PC, which survives a flush
  localparam logic [299:0] PC_KEEP_MASK = {236'b0, 32'hFFFF_FFFF, 32'b0};

  localparam logic [IF_ID_W-1:0]  IF_ID_KEEP_MASK  = PC_KEEP_MASK[IF_ID_W-1:0];
  localparam logic [ID_EX_W-1:0]  ID_EX_KEEP_MASK  = PC_KEEP_MASK[ID_EX_W-1:0];
  localparam logic [EX_MEM_W-1:0] EX_MEM_KEEP_MASK = PC_KEEP_MASK[EX_MEM_W-1:0];
  localparam logic [MEM_WB_W-1:0] MEM_WB_KEEP_MASK = PC_KEEP_MASK[MEM_WB_W-1:0];

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_ONE,
    OCC_FULL
  } occ_e;

endpackage

// File: rtl/pipe_stage_elastic_sat_counter.sv
// Saturating event counter; stops at all-ones and clears only on clr.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value
);

  always_ff @(negedge clk) begin
    if (clr) begin
      value <= '0;
    end else if (inc && (value != {W{1'b1}})) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register: valid/ready handshake, optional skid entry,
// keep-masked flush and saturating stall/flush counters. State moves on clk fall.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int                 WIDTH     = 300,
  parameter logic [WIDTH-1:0]   KEEP_MASK = PC_KEEP_MASK[WIDTH-1:0],
  parameter bit                 SKID      = 1'b1,
  parameter int                 CNT_W     = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  occ_e             occ_q, occ_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             main_valid, skid_valid;
  logic             accept, pop;

  assign main_valid = (occ_q != OCC_EMPTY);
  assign skid_valid = (occ_q == OCC_FULL);

  // With a skid entry, in_ready depends only on registered state
  generate
    if (SKID) begin : g_skid_ready
      assign in_ready = !skid_valid;
    end else begin : g_pass_ready
      assign in_ready = !main_valid || out_ready;
    end
  endgenerate

  assign out_valid = main_valid;
  assign out_data  = main_q;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    occ_d  = occ_q;
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      occ_d  = OCC_EMPTY;
      main_d = main_q & KEEP_MASK;
      skid_d = skid_q & KEEP_MASK;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (accept) begin
            main_d = in_data;
            occ_d  = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (accept && pop) begin
            main_d = in_data;
          end else if (accept && SKID) begin
            skid_d = in_data;
            occ_d  = OCC_FULL;
          end else if (pop) begin
            occ_d  = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            main_d = skid_q;
            occ_d  = OCC_ONE;
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(negedge clk) begin
    if (Rst) begin
      occ_q  <= OCC_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      occ_q  <= occ_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (Rst),
    .inc   (main_valid && !out_ready && !flush),
    .value (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr   (Rst),
    .inc   (flush && (main_valid || skid_valid)),
    .value (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic with a queue-based occupancy model
// checked on every rising edge, plus literal expectations at key points.
module tb_pipe_stage_elastic;

  localparam int W  = 300;
  localparam int CW = 4;
  localparam int SAT = 15;
  localparam logic [W-1:0] KEEP = {236'b0, 32'hFFFF_FFFF, 32'b0};

  logic          clk = 1'b0;
  logic          Rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  int tests_run = 0;
  int fail_cnt  = 0;

  pipe_stage_elastic #(
    .WIDTH (W),
    .SKID  (1'b1),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .Rst       (Rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  // Model: the stage is a FIFO of at most two payloads
  logic [W-1:0] mq[$];
  logic [W-1:0] m_out = '0;
  int           m_stall = 0;
  int           m_flush = 0;
  bit           model_ok = 1'b0;

  always @(negedge clk) begin
    if (Rst) begin
      mq.delete();
      m_out    = '0;
      m_stall  = 0;
      m_flush  = 0;
      model_ok = 1'b1;
    end else if (flush) begin
      if (mq.size() > 0 && m_flush < SAT) m_flush++;
      mq.delete();
      m_out = m_out & KEEP;
    end else begin
      bit acc, pp;
      acc = in_valid && (mq.size() < 2);
      pp  = (mq.size() > 0) && out_ready;
      if (mq.size() > 0 && !out_ready && m_stall < SAT) m_stall++;
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back(in_data);
      if (mq.size() > 0) m_out = mq[0];
    end
  end

  task automatic checkOutput(input string name, input logic [W-1:0] act,
                             input logic [W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (model_ok) begin
      checkOutput("model.out_valid", W'(out_valid), W'(mq.size() > 0));
      checkOutput("model.in_ready", W'(in_ready), W'(mq.size() < 2));
      checkOutput("model.out_data", out_data, m_out);
      checkOutput("model.stall_cnt", W'(stall_cnt), W'(m_stall));
      checkOutput("model.flush_cnt", W'(flush_cnt), W'(m_flush));
    end
  end

  // Drive inputs just after a rising edge, let one falling edge act on them
  task automatic applyStimulus(input logic rst, input logic fl, input logic iv,
                               input logic [W-1:0] d, input logic ordy);
    Rst       = rst;
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;

    applyStimulus(1, 0, 0, '0, 0);
    checkOutput("reset.out_valid", W'(out_valid), '0);
    checkOutput("reset.out_data", out_data, '0);
    checkOutput("reset.in_ready", W'(in_ready), W'(1));
    checkOutput("reset.stall_cnt", W'(stall_cnt), '0);

    // Basic pass-through
    applyStimulus(0, 0, 1, W'(5), 1);
    checkOutput("pass.out_valid", W'(out_valid), W'(1));
    checkOutput("pass.out_data", out_data, W'(5));
    checkOutput("pass.stall_cnt", W'(stall_cnt), '0);
    applyStimulus(0, 0, 0, '0, 1);
    checkOutput("pass.drain", W'(out_valid), '0);

    // Backpressure fill, then drain in order
    applyStimulus(0, 0, 1, W'(8'h11), 0);
    applyStimulus(0, 0, 1, W'(8'h22), 0);
    checkOutput("bp.full_data", out_data, W'(8'h11));
    checkOutput("bp.full_ready", W'(in_ready), '0);
    applyStimulus(0, 0, 1, W'(8'h33), 0);
    checkOutput("bp.c_blocked", out_data, W'(8'h11));
    checkOutput("bp.stall_cnt", W'(stall_cnt), W'(2));
    applyStimulus(0, 0, 1, W'(8'h33), 1);
    checkOutput("bp.second", out_data, W'(8'h22));
    applyStimulus(0, 0, 1, W'(8'h33), 1);
    checkOutput("bp.third", out_data, W'(8'h33));
    applyStimulus(0, 0, 0, '0, 1);
    checkOutput("bp.empty", W'(out_valid), '0);
    checkOutput("bp.stall_final", W'(stall_cnt), W'(2));

    // Flush with keep-mask
    applyStimulus(0, 0, 1, {W{1'b1}}, 0);
    applyStimulus(0, 1, 0, '0, 0);
    checkOutput("flush.out_valid", W'(out_valid), '0);
    checkOutput("flush.keep", out_data, KEEP);
    checkOutput("flush.cnt", W'(flush_cnt), W'(1));
    checkOutput("flush.no_stall", W'(stall_cnt), W'(2));
    applyStimulus(0, 1, 0, '0, 0);
    checkOutput("flush.empty_cnt", W'(flush_cnt), W'(1));

    // Flush beats a same-edge accept on a full stage
    applyStimulus(0, 0, 1, W'(8'h0A), 0);
    applyStimulus(0, 0, 1, W'(8'h0B), 0);
    checkOutput("fva.full", W'(in_ready), '0);
    applyStimulus(0, 1, 1, W'(8'h33), 0);
    checkOutput("fva.out_valid", W'(out_valid), '0);
    checkOutput("fva.in_ready", W'(in_ready), W'(1));
    checkOutput("fva.cnt", W'(flush_cnt), W'(2));
    applyStimulus(0, 0, 0, '0, 1);
    checkOutput("fva.dropped", W'(out_valid), '0);

    // Stall counter saturation
    applyStimulus(0, 0, 1, W'(8'h44), 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, '0, 0);
    checkOutput("sat.value", W'(stall_cnt), W'(SAT));
    applyStimulus(0, 0, 0, '0, 0);
    checkOutput("sat.hold", W'(stall_cnt), W'(SAT));

    // Reset overrides flush and accept on a full stage
    applyStimulus(0, 0, 1, W'(8'h55), 0);
    checkOutput("rst.full", W'(in_ready), '0);
    applyStimulus(1, 1, 1, W'(8'h66), 0);
    checkOutput("rst.out_valid", W'(out_valid), '0);
    checkOutput("rst.out_data", out_data, '0);
    checkOutput("rst.stall_cnt", W'(stall_cnt), '0);
    checkOutput("rst.flush_cnt", W'(flush_cnt), '0);
    checkOutput("rst.in_ready", W'(in_ready), W'(1));
    applyStimulus(0, 0, 0, '0, 1);
    checkOutput("rst.idle", W'(out_valid), '0);

    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
